// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
// Optional signed support is enabled by defining MULDIV_SIGNED_EN.
package muldiv_pkg;

  localparam int unsigned MULDIV_WIDTH = 32;

  typedef enum logic {
    OP_MUL = 1'b0,
    OP_DIV = 1'b1
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/muldiv_signfix.sv
// Conditional two's-complement negate; used for operand magnitudes and result
// sign fix-up when MULDIV_SIGNED_EN is defined.
module muldiv_signfix #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             neg_i,
  input  logic [WIDTH-1:0] val_i,
  output logic [WIDTH-1:0] val_o
);

  always_comb begin
    val_o = neg_i ? ('0 - val_i) : val_i;
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative 32-bit multiply (shift-add) / divide (restoring) unit with LO write-back.
// Define MULDIV_SIGNED_EN to add sign_i and two's-complement operation.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = MULDIV_WIDTH,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             op_i,
`ifdef MULDIV_SIGNED_EN
  input  logic             sign_i,
`endif
  input  logic [4:0]       wa_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             ready_o,
  output logic             done_o,
  output logic             regwrite_o,
  output logic [4:0]       wa_o,
  output logic [WIDTH-1:0] wd_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  state_e             state_q, state_d;
  op_e                op_q, op_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [4:0]         wa_q, wa_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic               div_nb;
  logic [WIDTH-1:0]   div_rem;
  logic [2*WIDTH-1:0] step_acc;
  logic [WIDTH-1:0]   res_hi, res_lo;

`ifdef MULDIV_SIGNED_EN
  logic               a_neg_q, a_neg_d, b_neg_q, b_neg_d;
  logic               a_neg_in, b_neg_in;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign a_neg_in = sign_i & a_i[WIDTH-1];
  assign b_neg_in = sign_i & b_i[WIDTH-1];

  muldiv_signfix #(.WIDTH(WIDTH)) u_mag_a (.neg_i(a_neg_in), .val_i(a_i), .val_o(a_mag));
  muldiv_signfix #(.WIDTH(WIDTH)) u_mag_b (.neg_i(b_neg_in), .val_i(b_i), .val_o(b_mag));
  muldiv_signfix #(.WIDTH(2*WIDTH)) u_fix_prod (
    .neg_i(a_neg_q ^ b_neg_q), .val_i(step_acc), .val_o(prod_fix));
  muldiv_signfix #(.WIDTH(WIDTH)) u_fix_quo (
    .neg_i(a_neg_q ^ b_neg_q), .val_i(step_acc[WIDTH-1:0]), .val_o(quo_fix));
  muldiv_signfix #(.WIDTH(WIDTH)) u_fix_rem (
    .neg_i(a_neg_q), .val_i(step_acc[2*WIDTH-1:WIDTH]), .val_o(rem_fix));

  // Divide by zero bypasses the quotient fix-up; the negated remainder magnitude
  // already reproduces the raw dividend.
  always_comb begin
    if (op_q == OP_MUL) begin
      {res_hi, res_lo} = prod_fix;
    end else begin
      res_hi = rem_fix;
      res_lo = (opnd_q == '0) ? '1 : quo_fix;
    end
  end
`else
  assign a_mag = a_i;
  assign b_mag = b_i;
  assign {res_hi, res_lo} = step_acc;
`endif

  // One datapath step: multiply shifts the accumulator right, divide shifts the
  // partial remainder left and records the no-borrow bit as the quotient LSB.
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_nb    = (div_shift >= {1'b0, opnd_q});
    div_rem   = div_nb ? (div_shift[WIDTH-1:0] - opnd_q) : div_shift[WIDTH-1:0];
    if (op_q == OP_MUL) begin
      step_acc = {mul_sum, acc_q[WIDTH-1:1]};
    end else begin
      step_acc = {div_rem, acc_q[WIDTH-2:0], div_nb};
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    wa_d    = wa_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
`ifdef MULDIV_SIGNED_EN
    a_neg_d = a_neg_q;
    b_neg_d = b_neg_q;
`endif
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_i) begin
          state_d = ST_CALC;
          op_d    = op_e'(op_i);
          cnt_d   = '0;
          wa_d    = wa_i;
          opnd_d  = (op_e'(op_i) == OP_MUL) ? a_mag : b_mag;
          acc_d   = {{WIDTH{1'b0}}, (op_e'(op_i) == OP_MUL) ? b_mag : a_mag};
`ifdef MULDIV_SIGNED_EN
          a_neg_d = a_neg_in;
          b_neg_d = b_neg_in;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CALC: begin
        acc_d = step_acc;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = ST_DONE;
          hi_d    = res_hi;
          lo_d    = res_lo;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= OP_MUL;
      cnt_q   <= '0;
      acc_q   <= '0;
      opnd_q  <= '0;
      wa_q    <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
`ifdef MULDIV_SIGNED_EN
      a_neg_q <= 1'b0;
      b_neg_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      wa_q    <= wa_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
`ifdef MULDIV_SIGNED_EN
      a_neg_q <= a_neg_d;
      b_neg_q <= b_neg_d;
`endif
    end
  end

  always_comb begin
    ready_o    = (state_q != ST_CALC);
    done_o     = (state_q == ST_DONE);
    regwrite_o = done_o & (wa_q != 5'd0);
    wa_o       = regwrite_o ? wa_q : '0;
    wd_o       = regwrite_o ? lo_q : '0;
    hi_o       = hi_q;
    lo_o       = lo_q;
  end

endmodule
